cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
Exception/ERET sequencer and timer that sits directly upstream of the CP0 register file and drives its single write port (waddr/wen/wdata). It takes exception, ERET and MTC0 requests from the pipeline's commit stage, keeps shadow copies of Status/Cause/EPC/BadVAddr, and runs Count/Compare. It serialises multi-register exception updates over several cycles, stalling the pipeline with busy, and issues flush plus a redirect PC.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, redirect target on exception
TICK_DIV, 2, clk cycles per Count increment (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset
exc_valid  in  1  exception request from commit stage
exc_code  in  5  ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
exc_pc  in  32  PC of faulting instruction
exc_bd  in  1  faulting instruction is in a delay slot
exc_badvaddr  in  32  faulting address (AdEL/AdES only)
eret  in  1  ERET committing
mtc0_we  in  1  MTC0 committing
mtc0_addr  in  5  CP0 register number
mtc0_wdata  in  32  MTC0 data
cp0_waddr  out  5  to register file waddr
cp0_wen  out  4  to register file wen (4'hF or 4'h0)
cp0_wdata  out  32  to register file wdata
flush  out  1  one-cycle pipeline flush
redirect_pc  out  32  fetch target, valid while flush=1
busy  out  1  stall pipeline; inputs ignored while high
int_req  out  1  interrupt pending (combinational)
cause_o  out  32  live Cause
count_o  out  32  live Count

Behaviour:
- Reset is synchronous and active-high (rst); the clock is clk. On reset: cp0_wen=0, cp0_waddr=0, cp0_wdata=0, flush=0, busy=0, redirect_pc=0, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick counter=0, Status=32'h0040_0000, FSM=IDLE.
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12 (IE b0, EXL b1, IM b15:8), Cause 13 (BD b31, TI b30, IP b15:8, ExcCode b6:2), EPC 14.
- All outputs except int_req, cause_o and count_o are registered.
- FSM states: IDLE, W_BADV, W_EPC, W_CAUSE, W_STATUS.
- busy=1 in every non-IDLE state.
- IDLE priority: exc_valid > eret > mtc0_we. Lower-priority requests in the same cycle are dropped.
- Exception accepted in cycle T:
  - Latch code, pc, bd and badvaddr.
  - flush=1 and redirect_pc=EXC_VECTOR in T+1 only.
  - Write sequence, one per cycle starting T+1: W_EPC, W_CAUSE, W_STATUS, then W_BADV only if code is 4 or 5, then IDLE.
  - EPC = exc_bd ? exc_pc-4 : exc_pc; Cause.BD = exc_bd.
  - If Status.EXL was already 1 at T: skip W_EPC and leave EPC and BD unchanged.
  - Cause.ExcCode = code.
  - Status is written with EXL=1.
  - Each write updates the shadow register and drives cp0_waddr/cp0_wdata with cp0_wen=4'hF in the same cycle.
- ERET accepted in cycle T:
  - flush=1 and redirect_pc=EPC shadow in T+1.
  - W_STATUS writes Status with EXL=0 in T+1, then IDLE.
- MTC0 in IDLE: one registered write at T+1; busy is not asserted.
  - Addr 13: only IP[1:0] (b9:8) is writable; other bits are kept.
  - Addr 9: loads Count and clears the tick counter.
  - Addr 11: loads Compare and clears TI.
  - Addr 12 and 14: update the shadow register.
  - Other addresses: forwarded unchanged.
- Timer:
  - Tick counter counts 0..TICK_DIV-1; Count increments when it wraps.
  - Count wraps from 32'hFFFF_FFFF to 0.
  - TI is set in the cycle after Count becomes equal to Compare.
  - TI stays set until an MTC0 to Compare.
  - Cause.IP[7] mirrors TI.
  - The timer keeps running while busy.
- int_req = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP).
- cause_o is live. The register-file copy of Cause is refreshed only in W_CAUSE or on an MTC0.

Optional Feature:
CP0_TIMER_EN:
- Defined: Count, Compare, the tick counter and TI are implemented as described above.
- Undefined: no timer logic is present.
  - count_o=0, TI=0, IP[7]=0.
  - MTC0 to addresses 9/11 is forwarded to the register file only; no internal effect.

Test Plan:
- rst for 2 cycles -> cp0_wen=0, busy=0, flush=0, Status=32'h0040_0000, count_o=0.
- exc_valid, code=12, pc=32'h0000_1000, bd=0, EXL=0 -> T+1: flush=1, redirect_pc=32'hBFC0_0380; writes (14,32'h1000), then (13, ExcCode=12), then (12, EXL=1); busy high for 3 cycles.
- exc_valid, code=4, bd=1, pc=32'h2004, badvaddr=32'h0000_0003 -> EPC=32'h2000, Cause.BD=1; 4 writes ending with (8,32'h3); busy high for 4 cycles.
- Second exception with EXL=1 -> no write to 14; EPC unchanged; 2 writes.
- eret after an exception -> flush=1, redirect_pc=EPC; Status written with EXL=0; then mtc0 to 13 with data 32'hFFFF_FFFF -> only IP[1:0] set.
- CP0_TIMER_EN defined, TICK_DIV=2, mtc0 Count=32'hFFFF_FFFE, Compare=0 -> Count wraps after 4 cycles; TI=1 one cycle later; int_req=1 if IE=1 and IM[7]=1; mtc0 Compare clears TI.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/ERET sequencer and Count/Compare timer driving the CP0 register-file write port.
// The Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int unsigned TICK_DIV   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  output logic [4:0]  cp0_waddr,
  output logic [3:0]  cp0_wen,
  output logic [31:0] cp0_wdata,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        int_req,
  output logic [31:0] cause_o,
  output logic [31:0] count_o
);
  typedef enum logic [2:0] {IDLE, W_BADV, W_EPC, W_CAUSE, W_STATUS} state_e;

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d, exl_q, exl_d, eret_q, eret_d;
  logic [31:0] badv_q, badv_d, status_q, status_d, epc_q, epc_d;
  logic        cause_bd_q, cause_bd_d;
  logic [4:0]  cause_code_q, cause_code_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d, redirect_q, redirect_d, cause_s;
  logic        flush_q, flush_d, busy_q;
  logic        ti_q, ti_d;
  logic        idle_s, acc_mtc0_s, eff_bd_s, eff_exl_s;
  logic [4:0]  eff_code_s;

  function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                             input logic [1:0] ip_sw, input logic [4:0] code);
    return {bd, ti, 14'd0, ti, 5'd0, ip_sw, 1'b0, code, 2'b00};
  endfunction

  // The first write of a sequence happens while still in IDLE, so it must use the live request.
  assign idle_s     = (state_q == IDLE);
  assign acc_mtc0_s = idle_s & ~exc_valid & ~eret & mtc0_we;
  assign eff_code_s = idle_s ? exc_code : code_q;
  assign eff_bd_s   = idle_s ? exc_bd : bd_q;
  assign eff_exl_s  = idle_s ? status_q[1] : exl_q;

`ifdef CP0_TIMER_EN
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [31:0]   count_q, count_d, compare_q, compare_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          match_q, match_d;

  // Timer next state; TI follows one cycle after Count steps onto Compare.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    tick_d    = tick_q;
    match_d   = 1'b0;
    ti_d      = ti_q;
    if (acc_mtc0_s && (mtc0_addr == 5'd11)) begin
      compare_d = mtc0_wdata;
      ti_d      = 1'b0;
    end else begin
      ti_d = ti_q | match_q;
    end
    if (acc_mtc0_s && (mtc0_addr == 5'd9)) begin
      count_d = mtc0_wdata;
      tick_d  = '0;
    end else if (tick_q == TICK_LAST) begin
      tick_d  = '0;
      count_d = count_q + 32'd1;
      match_d = (count_d == compare_d);
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      tick_q    <= '0;
      match_q   <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      match_q   <= match_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o = count_q;
`else
  assign ti_q    = 1'b0;
  assign ti_d    = 1'b0;
  assign count_o = 32'd0;
`endif

  // Sequencer next state, plus the write-port action for the state being entered.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    bd_d         = bd_q;
    exl_d        = exl_q;
    eret_d       = eret_q;
    badv_d       = badv_q;
    status_d     = status_q;
    epc_d        = epc_q;
    cause_bd_d   = cause_bd_q;
    cause_code_d = cause_code_q;
    ip_sw_d      = ip_sw_q;
    wen_d        = 4'h0;
    waddr_d      = 5'd0;
    wdata_d      = 32'd0;
    flush_d      = 1'b0;
    redirect_d   = redirect_q;
    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          code_d     = exc_code;
          bd_d       = exc_bd;
          exl_d      = status_q[1];
          eret_d     = 1'b0;
          badv_d     = ((exc_code == 5'd4) || (exc_code == 5'd5)) ? exc_badvaddr : badv_q;
          state_d    = status_q[1] ? W_CAUSE : W_EPC;
          flush_d    = 1'b1;
          redirect_d = EXC_VECTOR;
        end else if (eret) begin
          eret_d     = 1'b1;
          state_d    = W_STATUS;
          flush_d    = 1'b1;
          redirect_d = epc_q;
        end else begin
          state_d = IDLE;
        end
      end
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = W_STATUS;
      W_STATUS: state_d = (!eret_q && ((code_q == 5'd4) || (code_q == 5'd5))) ? W_BADV : IDLE;
      W_BADV:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    case (state_d)
      W_EPC: begin
        epc_d   = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        wen_d   = 4'hF;
        waddr_d = 5'd14;
        wdata_d = epc_d;
      end
      W_CAUSE: begin
        cause_code_d = eff_code_s;
        cause_bd_d   = eff_exl_s ? cause_bd_q : eff_bd_s;
        wen_d        = 4'hF;
        waddr_d      = 5'd13;
        wdata_d      = pack_cause(cause_bd_d, ti_d, ip_sw_q, cause_code_d);
      end
      W_STATUS: begin
        // Entered from IDLE only by ERET (clear EXL); otherwise an exception sets it.
        status_d = {status_q[31:2], ~idle_s, status_q[0]};
        wen_d    = 4'hF;
        waddr_d  = 5'd12;
        wdata_d  = status_d;
      end
      W_BADV: begin
        wen_d   = 4'hF;
        waddr_d = 5'd8;
        wdata_d = badv_q;
      end
      IDLE: begin
        if (acc_mtc0_s) begin
          wen_d   = 4'hF;
          waddr_d = mtc0_addr;
          wdata_d = mtc0_wdata;
          case (mtc0_addr)
            5'd12: status_d = mtc0_wdata;
            5'd13: begin
              ip_sw_d = mtc0_wdata[9:8];
              wdata_d = pack_cause(cause_bd_q, ti_d, ip_sw_d, cause_code_q);
            end
            5'd14: epc_d = mtc0_wdata;
            default: wdata_d = mtc0_wdata;
          endcase
        end else begin
          wen_d = 4'h0;
        end
      end
      default: wen_d = 4'h0;
    endcase
  end

  // Sequencer, shadow and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= 5'd0;
      bd_q         <= 1'b0;
      exl_q        <= 1'b0;
      eret_q       <= 1'b0;
      badv_q       <= 32'd0;
      status_q     <= 32'h0040_0000;
      epc_q        <= 32'd0;
      cause_bd_q   <= 1'b0;
      cause_code_q <= 5'd0;
      ip_sw_q      <= 2'd0;
      waddr_q      <= 5'd0;
      wen_q        <= 4'h0;
      wdata_q      <= 32'd0;
      flush_q      <= 1'b0;
      redirect_q   <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      bd_q         <= bd_d;
      exl_q        <= exl_d;
      eret_q       <= eret_d;
      badv_q       <= badv_d;
      status_q     <= status_d;
      epc_q        <= epc_d;
      cause_bd_q   <= cause_bd_d;
      cause_code_q <= cause_code_d;
      ip_sw_q      <= ip_sw_d;
      waddr_q      <= waddr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign cause_s     = pack_cause(cause_bd_q, ti_q, ip_sw_q, cause_code_q);
  assign cause_o     = cause_s;
  assign int_req     = status_q[0] & ~status_q[1] & (|(status_q[15:8] & cause_s[15:8]));
  assign cp0_waddr   = waddr_q;
  assign cp0_wen     = wen_q;
  assign cp0_wdata   = wdata_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomised bench for cp0_exc_ctrl against a transaction-level model of the CP0 exception rules.
module tb_cp0_exc_ctrl;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam int          TDIV = 2;
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_bd, eret, mtc0_we;
  logic [4:0]  exc_code, mtc0_addr;
  logic [31:0] exc_pc, exc_badvaddr, mtc0_wdata;
  logic [4:0]  cp0_waddr;
  logic [3:0]  cp0_wen;
  logic [31:0] cp0_wdata, redirect_pc, cause_o, count_o;
  logic        flush, busy, int_req;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.EXC_VECTOR(VEC), .TICK_DIV(TDIV)) dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret(eret), .mtc0_we(mtc0_we),
    .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata), .cp0_waddr(cp0_waddr), .cp0_wen(cp0_wen),
    .cp0_wdata(cp0_wdata), .flush(flush), .redirect_pc(redirect_pc), .busy(busy),
    .int_req(int_req), .cause_o(cause_o), .count_o(count_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Model: pending register-file writes queued per accepted request, one drained per cycle.
  typedef enum int {OP_EPC, OP_CAUSE, OP_SSET, OP_SCLR, OP_BADV, OP_MTC0} op_k;
  typedef struct {op_k k; logic [4:0] a; logic [31:0] v; bit bd; bit upd;} op_t;
  op_t q[$];

  logic [31:0] m_status, m_epc, m_count, m_cmp, e_data, e_redir;
  logic [4:0]  m_code, e_addr;
  logic [1:0]  m_ipsw;
  bit          m_bd, m_ti, m_tipend, e_wen, e_busy, e_flush;
  int          m_tick;

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ti) << 15) |
           (32'(m_ipsw) << 8) | (32'(m_code) << 2);
  endfunction

  function automatic logic exp_int();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] && !m_status[1] && ((m_status[15:8] & c[15:8]) != 8'd0);
  endfunction

  task automatic m_reset();
    m_status = 32'h0040_0000; m_epc = 32'd0; m_count = 32'd0; m_cmp = 32'd0;
    m_code = 5'd0; m_ipsw = 2'd0; m_bd = 1'b0; m_ti = 1'b0; m_tipend = 1'b0; m_tick = 0;
    e_wen = 1'b0; e_busy = 1'b0; e_flush = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_redir = 32'd0;
    q.delete();
  endtask

  task automatic model_step();
    bit  a_exc, a_eret, a_mtc;
    op_t o;
    a_exc  = !e_busy && exc_valid;
    a_eret = !e_busy && !exc_valid && eret;
    a_mtc  = !e_busy && !exc_valid && !eret && mtc0_we;
    if (TIMER) begin
      if (a_mtc && mtc0_addr == 5'd11) m_ti = 1'b0;
      else if (m_tipend) m_ti = 1'b1;
      m_tipend = 1'b0;
      if (a_mtc && mtc0_addr == 5'd11) m_cmp = mtc0_wdata;
      if (a_mtc && mtc0_addr == 5'd9) begin
        m_count = mtc0_wdata; m_tick = 0;
      end else begin
        m_tick++;
        if (m_tick == TDIV) begin
          m_tick = 0; m_count = m_count + 32'd1; m_tipend = (m_count == m_cmp);
        end
      end
    end
    e_flush = a_exc || a_eret;
    if (a_exc) e_redir = VEC;
    else if (a_eret) e_redir = m_epc;
    if (a_exc) begin
      if (!m_status[1]) q.push_back('{OP_EPC, 5'd14, exc_bd ? exc_pc - 32'd4 : exc_pc, 1'b0, 1'b0});
      q.push_back('{OP_CAUSE, 5'd13, {27'd0, exc_code}, exc_bd, !m_status[1]});
      q.push_back('{OP_SSET, 5'd12, 32'd0, 1'b0, 1'b0});
      if (exc_code == 5'd4 || exc_code == 5'd5) q.push_back('{OP_BADV, 5'd8, exc_badvaddr, 1'b0, 1'b0});
    end else if (a_eret) q.push_back('{OP_SCLR, 5'd12, 32'd0, 1'b0, 1'b0});
    else if (a_mtc) q.push_back('{OP_MTC0, mtc0_addr, mtc0_wdata, 1'b0, 1'b0});
    e_wen = 1'b0; e_busy = 1'b0;
    if (q.size() > 0) begin
      o = q.pop_front();
      e_wen = 1'b1; e_busy = (o.k != OP_MTC0); e_addr = o.a; e_data = o.v;
      case (o.k)
        OP_EPC:   m_epc = o.v;
        OP_CAUSE: begin m_code = o.v[4:0]; if (o.upd) m_bd = o.bd; e_data = m_cause(); end
        OP_SSET:  begin m_status[1] = 1'b1; e_data = m_status; end
        OP_SCLR:  begin m_status[1] = 1'b0; e_data = m_status; end
        OP_MTC0: begin
          if (o.a == 5'd13) begin m_ipsw = o.v[9:8]; e_data = m_cause(); end
          else if (o.a == 5'd12) m_status = o.v;
          else if (o.a == 5'd14) m_epc = o.v;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("busy", 32'(busy), 32'(e_busy));
    chk("flush", 32'(flush), 32'(e_flush));
    if (e_flush) chk("redirect_pc", redirect_pc, e_redir);
    chk("cp0_wen", 32'(cp0_wen), e_wen ? 32'hF : 32'h0);
    if (e_wen) begin
      chk("cp0_waddr", 32'(cp0_waddr), 32'(e_addr));
      chk("cp0_wdata", cp0_wdata, e_data);
    end
    chk("cause_o", cause_o, m_cause());
    chk("count_o", count_o, TIMER ? m_count : 32'd0);
    chk("int_req", 32'(int_req), 32'(exp_int()));
  endtask

  task automatic drive(input logic ev, input logic [4:0] code, input logic [31:0] pc, input logic bd,
                       input logic [31:0] badv, input logic er, input logic mw,
                       input logic [4:0] ma, input logic [31:0] md);
    exc_valid = ev; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badvaddr = badv;
    eret = er; mtc0_we = mw; mtc0_addr = ma; mtc0_wdata = md;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  logic [4:0] codes [0:6] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
  logic [4:0] addrs [0:7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd0};

  initial begin
    rst = 1'b1;
    exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0; exc_badvaddr = 32'd0;
    eret = 1'b0; mtc0_we = 1'b0; mtc0_addr = 5'd0; mtc0_wdata = 32'd0;
    repeat (2) @(posedge clk);
    m_reset();
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    chk("reset_wen", 32'(cp0_wen), 32'd0);
    chk("reset_count", count_o, 32'd0);
    chk("reset_cause", cause_o, 32'd0);
    compare_all();
    rst = 1'b0;

    drive(1'b1, 5'd12, 32'h0000_1000, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(4);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(2);
    drive(1'b1, 5'd4, 32'h0000_2004, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(5);
    drive(1'b1, 5'd8, 32'h0000_3000, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(3);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(2);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd12, 32'h0000_8001);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd9, 32'hFFFF_FFFE);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd11, 32'd0);
    idle(8);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd11, 32'd7);
    idle(2);
    // Simultaneous requests: exception wins, then ERET over MTC0.
    drive(1'b1, 5'd5, 32'h0000_4000, 1'b0, 32'h0000_0011, 1'b1, 1'b1, 5'd14, 32'h1234_5678);
    idle(5);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 5'd14, 32'h1234_5678);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) == 0, codes[$urandom_range(0, 6)], $urandom, 1'($urandom),
            $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
            addrs[$urandom_range(0, 7)], $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
